// File: rtl/packed_cmd_arbiter_pkg.sv
// Shared types for the packed-command arbiter: FSM encodings and the
// {write_not_read, addr, data} command layout reused by the packer blocks.
package packed_cmd_arbiter_pkg;

  localparam int cmd_we_w_lp   = 1;
  localparam int cmd_addr_w_lp = 23;
  localparam int cmd_data_w_lp = 8;
  localparam int cmd_w_lp      = cmd_we_w_lp + cmd_addr_w_lp + cmd_data_w_lp;

  typedef struct packed {
    logic                     write_not_read;
    logic [cmd_addr_w_lp-1:0] addr;
    logic [cmd_data_w_lp-1:0] data;
  } packed_cmd_s;

  typedef logic [1:0] state_t;

  localparam state_t e_idle      = 2'd0;
  localparam state_t e_read_wait = 2'd1;
  localparam state_t e_read_err  = 2'd2;

  function automatic logic cmd_is_write(input logic [cmd_w_lp-1:0] cmd);
    packed_cmd_s c;
    c = packed_cmd_s'(cmd);
    return c.write_not_read;
  endfunction

endpackage

// File: rtl/packed_cmd_rr_select.sv
// Round-robin pick: first asserted valid at or after ptr, wrapping.
// Purely combinational; returns both one-hot and binary forms of the grant.
module packed_cmd_rr_select #(
  parameter int num_req_p = 2,
  localparam int idx_w_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] valid,
  input  logic [idx_w_lp-1:0]  ptr,
  output logic [num_req_p-1:0] grant_oh,
  output logic [idx_w_lp-1:0]  grant_idx
);

  logic                found;
  logic [idx_w_lp-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = idx_w_lp'((int'(ptr) + i) % num_req_p);
      if (!found && valid[cand]) begin
        found           = 1'b1;
        grant_oh[cand]  = 1'b1;
        grant_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/packed_cmd_arbiter.sv
// Arbitrates packed commands from several requesters onto one downstream
// channel, allowing a single outstanding read with a response timeout.
//
// state       | meaning
// e_idle      | forwarding commands round-robin; any response here is stray
// e_read_wait | read issued for owner, waiting for downstream response
// e_read_err  | read timed out, offering err_data_p to owner
module packed_cmd_arbiter
  import packed_cmd_arbiter_pkg::*;
#(
  parameter int          num_req_p  = 2,
  parameter int          timeout_p  = 1024,
  parameter logic [31:0] err_data_p = 32'hDEAD_0BAD,
  localparam int         idx_w_lp   = $clog2(num_req_p),
  localparam int         tmr_w_lp   = $clog2(timeout_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [32*num_req_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]    req_v_i,
  output logic [num_req_p-1:0]    req_ready_o,
  output logic [31:0]             resp_data_o,
  output logic [num_req_p-1:0]    resp_v_o,
  input  logic [num_req_p-1:0]    resp_ready_i,
  output logic [31:0]             data_o,
  output logic                    v_o,
  input  logic                    ready_i,
  input  logic [31:0]             data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    timeout_o,
  output logic                    stray_o
);

  state_t               state_r;
  logic [idx_w_lp-1:0]  rr_ptr_r;
  logic [idx_w_lp-1:0]  owner_r;
  logic [idx_w_lp-1:0]  grant_idx;
  logic [num_req_p-1:0] grant_oh;
  logic [num_req_p-1:0] owner_oh;
  logic [tmr_w_lp-1:0]  timer_r;
  logic                 timeout_r;
  logic                 stray_r;
  logic [31:0]          req_cmd [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_cmd
    assign req_cmd[g] = req_data_i[g*32 +: 32];
  end

  packed_cmd_rr_select #(.num_req_p(num_req_p)) u_rr_select (
    .valid     (req_v_i),
    .ptr       (rr_ptr_r),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign data_o    = req_cmd[grant_idx];
  assign owner_oh  = {{(num_req_p-1){1'b0}}, 1'b1} << owner_r;
  assign timeout_o = timeout_r;
  assign stray_o   = stray_r;

  // Handshake outputs are forced quiet while reset is held.
  always_comb begin
    v_o         = 1'b0;
    req_ready_o = '0;
    resp_v_o    = '0;
    resp_data_o = data_i;
    ready_o     = 1'b0;
    if (!reset_i) begin
      unique case (state_r)
        e_idle: begin
          v_o         = |req_v_i;
          req_ready_o = grant_oh & {num_req_p{ready_i}};
          ready_o     = 1'b1;
        end
        e_read_wait: begin
          resp_v_o = owner_oh & {num_req_p{v_i}};
          ready_o  = resp_ready_i[owner_r];
        end
        e_read_err: begin
          resp_data_o = err_data_p;
          resp_v_o    = owner_oh;
          ready_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      timer_r   <= '0;
      timeout_r <= 1'b0;
      stray_r   <= 1'b0;
    end else begin
      unique case (state_r)
        e_idle: begin
          if (v_i) stray_r <= 1'b1;
          if (v_o && ready_i) begin
            rr_ptr_r <= (grant_idx == idx_w_lp'(num_req_p - 1)) ? '0
                                                                : grant_idx + idx_w_lp'(1);
            if (!cmd_is_write(data_o)) begin
              owner_r <= grant_idx;
              timer_r <= '0;
              state_r <= e_read_wait;
            end
          end
        end
        e_read_wait: begin
          // A response landing on the terminal cycle beats the timeout.
          if (v_i && ready_o) begin
            state_r <= e_idle;
          end else if (timer_r == tmr_w_lp'(timeout_p - 1)) begin
            state_r   <= e_read_err;
            timeout_r <= 1'b1;
          end else if (timer_r != '1) begin
            timer_r <= timer_r + tmr_w_lp'(1);
          end
        end
        e_read_err: begin
          if (resp_ready_i[owner_r]) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: doc/packed_cmd_arbiter.md
PACKED_CMD_ARBITER -- requirements
Module: packed_cmd_arbiter

Interface
REQ-001 Parameter: num_req_p, default 2, number of packed-command requesters (2..8).
REQ-002 Parameter: timeout_p, default 1024, cycles allowed for a read response before the block synthesizes an error response.
REQ-003 Parameter: err_data_p, default 32'hDEAD_0BAD, read data returned on timeout.
REQ-004 Port: clk_i  input  1  sole clock, all state updates on the rising edge.
REQ-005 Port: reset_i  input  1  reset, synchronous, active-high.
REQ-006 Port: req_data_i  input  32*num_req_p  packed command per requester, {write_not_read, addr[22:0], data[7:0]}.
REQ-007 Port: req_v_i / req_ready_o  input/output  num_req_p  per-requester command handshake.
REQ-008 Port: resp_data_o  output  32  read data, broadcast to all requesters.
REQ-009 Port: resp_v_o / resp_ready_i  output/input  num_req_p  per-requester read-response handshake.
REQ-010 Port: data_o, v_o / ready_i  output 32, output 1 / input 1  packed command to the shared downstream channel.
REQ-011 Port: data_i, v_i / ready_o  input 32, input 1 / output 1  read response from the downstream channel.
REQ-012 Port: timeout_o  output  1  sticky flag, set on any read timeout.
REQ-013 Port: stray_o  output  1  sticky flag, set when a response arrives with no read outstanding.

Function
REQ-014 States: e_idle, e_read_wait, e_read_err; exactly one read is outstanding at a time.
REQ-015 e_idle: grant = first asserted req_v_i at or after rr_ptr (wrapping); v_o = |req_v_i; data_o = granted req_data_i; req_ready_o[grant] = ready_i; all other req_ready_o = 0.
REQ-016 The command path is combinational; command latency is 0 cycles.
REQ-017 On an e_idle handshake (v_o & ready_i), rr_ptr <= grant+1 mod num_req_p.
REQ-018 On an e_idle handshake with data_o[31]=1 (write), the block stays in e_idle; writes carry no response.
REQ-019 On an e_idle handshake with data_o[31]=0 (read), owner <= grant, timer <= 0, and the next state is e_read_wait.
REQ-020 e_read_wait: v_o = 0; all req_ready_o = 0; resp_data_o = data_i; resp_v_o[owner] = v_i; ready_o = resp_ready_i[owner].
REQ-021 e_read_wait: on v_i & ready_o, go to e_idle; otherwise timer increments each cycle.
REQ-022 e_read_wait: if timer = timeout_p-1 and no response handshake occurs that cycle, go to e_read_err and set timeout_o.
REQ-023 e_read_err: resp_data_o = err_data_p; resp_v_o[owner] = 1; ready_o = 1 (drops late data); on resp_ready_i[owner], go to e_idle.
REQ-024 In e_idle, ready_o = 1; any v_i seen in e_idle sets stray_o and the data is discarded.
REQ-025 If a response and the timeout fall in the same cycle, the response wins; no timeout is flagged.
REQ-026 resp_v_o is one-hot or zero at all times; resp_v_o and resp_data_o hold stable until accepted.
REQ-027 Timer width is clog2(timeout_p+1) bits; the timer saturates and never wraps.

Reset
REQ-028 While reset_i is asserted, outputs are: state = e_idle, rr_ptr = 0, owner = 0, timer = 0, timeout_o = 0, stray_o = 0, v_o = 0, all resp_v_o = 0, all req_ready_o = 0.
REQ-029 Reset in the middle of a read abandons it without generating a response; the first post-reset v_i sets stray_o.

Structure
REQ-030 The state enum and the packed-command field widths (1/23/8) belong in a shared package, reused by the packer blocks.
REQ-031 Grant selection is one sub-module, packed_cmd_rr_select: input valid vector and pointer, output one-hot grant and index, purely combinational.

Verification
REQ-032 Directed test, simultaneous requests: req_v_i=2'b11 with both commands writes and ready_i=1 for 2 cycles -> requester 0 is granted then requester 1, and data_o matches each command.
REQ-033 Directed test, read return: requester 1 issues 32'h0012_3400 and downstream returns 32'hA5 after 5 cycles -> resp_v_o=2'b10, resp_data_o=32'hA5, and no command is granted meanwhile.
REQ-034 Directed test, timeout: timeout_p=16 and no v_i -> resp_v_o[owner] rises 16 cycles after the grant with data 32'hDEAD_0BAD, and timeout_o=1.
REQ-035 Directed test, late data after timeout: v_i arrives in e_read_err or e_idle -> the data is dropped, stray_o=1 only when it arrives in e_idle, and the next read returns correct data.
REQ-036 Directed test, backpressure: ready_i=0 for 3 cycles, then resp_ready_i=0 for 4 cycles -> data_o and resp_data_o hold stable, and there is no duplicate or lost transaction.
REQ-037 Directed test, reset in e_read_wait: assert reset_i, then inject v_i -> state=e_idle and stray_o=1.
